// File: rtl/anim_sequencer.sv
// anim_sequencer
// Sequences LCD animation playback for the pet display. The scan address
// that the SPI LCD driver walks through is watched to find frame boundaries
// (last pixel of a frame followed by pixel (0,0)). The animation select and
// frame index only change on those boundaries, so a frame is never torn.
// A rising edge on go_i queues a one-shot animation. It starts at the next
// boundary when idle, or after the current one-shot finishes. Playback then
// falls back to the looping idle animation (anim_sel_o = 0).
//
// Handshake: there is no valid/ready pair. go_i is a level input, and only
// its rising edge is a request. Requests are never refused: the latest
// request overwrites any request that is still pending.
//
// Ports
//   clk           in   1  system clock
//   rst           in   1  synchronous active-high reset
//   go_i          in   1  play request (rising edge detected internally)
//   mode_req_i    in   2  animation to play on go (1..3, 0 treated as 1)
//   pix_x_i       in   8  current driver column address
//   pix_y_i       in   8  current driver row address
//   anim_sel_o    out  2  active animation (0 = idle loop)
//   frame_idx_o   out  2  active frame within anim_sel_o
//   frame_tick_o  out  1  one-cycle pulse at each frame boundary
//   busy_o        out  1  one-shot pending or playing
//   state_o       out  1  debug view of the FSM state (0 = LOOP, 1 = PLAY)
module anim_sequencer #(
    parameter int LCD_W       = 132,
    parameter int LCD_H       = 162,
    parameter int NUM_FRAMES  = 4,
    parameter int HOLD_FRAMES = 6
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       go_i,
    input  logic [1:0] mode_req_i,
    input  logic [7:0] pix_x_i,
    input  logic [7:0] pix_y_i,
    output logic [1:0] anim_sel_o,
    output logic [1:0] frame_idx_o,
    output logic       frame_tick_o,
    output logic       busy_o,
    output logic       state_o
);

    localparam int HW = (HOLD_FRAMES > 1) ? $clog2(HOLD_FRAMES) : 1;

    localparam logic [7:0]    X_LAST     = 8'(LCD_W - 1);
    localparam logic [7:0]    Y_LAST     = 8'(LCD_H - 1);
    localparam logic [HW-1:0] HOLD_LAST  = HW'(HOLD_FRAMES - 1);
    localparam logic [1:0]    FRAME_LAST = 2'(NUM_FRAMES - 1);

    typedef enum logic {
        ST_LOOP = 1'b0,
        ST_PLAY = 1'b1
    } state_t;

    state_t        state_q, state_d;
    logic [7:0]    pix_x_q, pix_y_q;
    logic          go_q;
    logic          pend_valid_q, pend_valid_d;
    logic [1:0]    pend_anim_q, pend_anim_d;
    logic [HW-1:0] hold_cnt_q, hold_cnt_d;
    logic [1:0]    anim_sel_q, anim_sel_d;
    logic [1:0]    frame_idx_q, frame_idx_d;
    logic          frame_tick_q, frame_tick_d;
    logic          busy_q, busy_d;

    logic          boundary;
    logic          go_rise;
    logic [1:0]    req_anim;
    logic          hold_wrap;
    logic          frame_last;
    logic [1:0]    frame_next;

    // A boundary needs the previous address to be the last pixel and the
    // current one to be the origin. If the scan stalls on either address,
    // this is true for only one cycle.
    assign boundary   = (pix_x_q == X_LAST) && (pix_y_q == Y_LAST) &&
                        (pix_x_i == 8'd0)   && (pix_y_i == 8'd0);
    assign go_rise    = go_i && !go_q;
    assign req_anim   = (mode_req_i == 2'd0) ? 2'd1 : mode_req_i;
    assign hold_wrap  = (hold_cnt_q == HOLD_LAST);
    assign frame_last = (frame_idx_q == FRAME_LAST);
    assign frame_next = frame_last ? 2'd0 : frame_idx_q + 2'd1;

    always_comb begin
        state_d      = state_q;
        pend_valid_d = pend_valid_q;
        pend_anim_d  = pend_anim_q;
        hold_cnt_d   = hold_cnt_q;
        anim_sel_d   = anim_sel_q;
        frame_idx_d  = frame_idx_q;
        frame_tick_d = boundary;

        if (boundary) begin
            hold_cnt_d = hold_wrap ? '0 : hold_cnt_q + 1'b1;
            case (state_q)
                ST_LOOP: begin
                    // A pending start wins over an idle frame advance.
                    if (pend_valid_q) begin
                        state_d      = ST_PLAY;
                        anim_sel_d   = pend_anim_q;
                        frame_idx_d  = 2'd0;
                        hold_cnt_d   = '0;
                        pend_valid_d = 1'b0;
                    end else if (hold_wrap) begin
                        frame_idx_d = frame_next;
                    end
                end
                ST_PLAY: begin
                    if (hold_wrap) begin
                        if (!frame_last) begin
                            frame_idx_d = frame_next;
                        end else if (pend_valid_q) begin
                            // Chain straight into the queued one-shot, with
                            // no idle frame in between.
                            anim_sel_d   = pend_anim_q;
                            frame_idx_d  = 2'd0;
                            pend_valid_d = 1'b0;
                        end else begin
                            state_d     = ST_LOOP;
                            anim_sel_d  = 2'd0;
                            frame_idx_d = 2'd0;
                        end
                    end
                end
                default: state_d = ST_LOOP;
            endcase
        end

        // This is applied after consumption. A request that arrives on a
        // boundary cycle therefore stays pending until the next boundary.
        if (go_rise) begin
            pend_valid_d = 1'b1;
            pend_anim_d  = req_anim;
        end

        busy_d = pend_valid_d || (state_d == ST_PLAY);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_LOOP;
            pix_x_q      <= 8'd0;
            pix_y_q      <= 8'd0;
            go_q         <= 1'b0;
            pend_valid_q <= 1'b0;
            pend_anim_q  <= 2'd0;
            hold_cnt_q   <= '0;
            anim_sel_q   <= 2'd0;
            frame_idx_q  <= 2'd0;
            frame_tick_q <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            pix_x_q      <= pix_x_i;
            pix_y_q      <= pix_y_i;
            go_q         <= go_i;
            pend_valid_q <= pend_valid_d;
            pend_anim_q  <= pend_anim_d;
            hold_cnt_q   <= hold_cnt_d;
            anim_sel_q   <= anim_sel_d;
            frame_idx_q  <= frame_idx_d;
            frame_tick_q <= frame_tick_d;
            busy_q       <= busy_d;
        end
    end

    assign anim_sel_o   = anim_sel_q;
    assign frame_idx_o  = frame_idx_q;
    assign frame_tick_o = frame_tick_q;
    assign busy_o       = busy_q;
    assign state_o      = state_q;

endmodule
